// File: rtl/merge_ctrl_param.sv
// Two-way merge of sorted, zero-terminated record runs into one sorted run.
// Dequeue decisions are combinational; the write port and run bookkeeping are registered.
module merge_ctrl_param #(
  parameter int DATA_W  = 32,
  parameter int KEY_W   = 32,
  parameter bit DESCEND = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_a_data,
  input  logic              i_a_empty,
  output logic              o_a_deq,
  input  logic [DATA_W-1:0] i_b_data,
  input  logic              i_b_empty,
  output logic              o_b_deq,
  input  logic              i_out_full,
  output logic              o_out_wr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_stall,
  output logic              o_run_done,
  output logic [CNT_W-1:0]  o_run_count
);

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [KEY_W-1:0]  key_a, key_b;
  logic              ta, tb, a_wins, stall;
  logic              wr_next, done_next;
  logic [DATA_W-1:0] data_next;

  assign key_a = i_a_data[DATA_W-1 -: KEY_W];
  assign key_b = i_b_data[DATA_W-1 -: KEY_W];
  assign ta    = !i_a_empty && (i_a_data == '0);
  assign tb    = !i_b_empty && (i_b_data == '0);

  // Ties always favour A, in both directions.
  if (DESCEND) begin : g_desc
    assign a_wins = (key_a >= key_b);
  end else begin : g_asc
    assign a_wins = (key_a <= key_b);
  end

  always_comb begin
    stall = 1'b1;
    if (!i_rst) begin
      case (state)
        MERGE:   stall = i_out_full | i_a_empty | i_b_empty;
        DRAIN_A: stall = i_out_full | i_a_empty;
        DRAIN_B: stall = i_out_full | i_b_empty;
        default: stall = 1'b1;
      endcase
    end
  end

  assign o_stall = stall;

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    o_a_deq    = 1'b0;
    o_b_deq    = 1'b0;
    wr_next    = 1'b0;
    data_next  = '0;
    done_next  = 1'b0;
    case (state)
      MERGE: if (!stall) begin
        wr_next = 1'b1;
        if (ta && tb) begin
          o_a_deq   = 1'b1;
          o_b_deq   = 1'b1;
          done_next = 1'b1;
        end else if (ta) begin
          o_b_deq    = 1'b1;
          data_next  = i_b_data;
          state_next = DRAIN_B;
        end else if (tb) begin
          o_a_deq    = 1'b1;
          data_next  = i_a_data;
          state_next = DRAIN_A;
        end else if (a_wins) begin
          o_a_deq   = 1'b1;
          data_next = i_a_data;
        end else begin
          o_b_deq   = 1'b1;
          data_next = i_b_data;
        end
      end
      // The idle run's terminator is still parked at its FIFO head; it is popped with ours.
      DRAIN_A: if (!stall) begin
        wr_next = 1'b1;
        o_a_deq = 1'b1;
        if (ta) begin
          o_b_deq    = 1'b1;
          done_next  = 1'b1;
          state_next = MERGE;
        end else begin
          data_next = i_a_data;
        end
      end
      DRAIN_B: if (!stall) begin
        wr_next = 1'b1;
        o_b_deq = 1'b1;
        if (tb) begin
          o_a_deq    = 1'b1;
          done_next  = 1'b1;
          state_next = MERGE;
        end else begin
          data_next = i_b_data;
        end
      end
      default: state_next = MERGE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= MERGE;
      o_out_wr    <= 1'b0;
      o_out_data  <= '0;
      o_run_done  <= 1'b0;
      o_run_count <= '0;
    end else begin
      state      <= state_next;
      o_out_wr   <= wr_next;
      o_run_done <= done_next;
      if (wr_next) o_out_data <= data_next;
      if (done_next) o_run_count <= o_run_count + CNT_W'(1);
    end
  end

endmodule
